operand_nibble_tx: RTL and testbench
====================================

OPERAND_NIBBLE_TX -- requirements
Module: operand_nibble_tx

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 0: idle cycles inserted between consecutive nibble transfers (0..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to transmit the current a/b pair.
REQ-005 SHALL have port a, input, 8, operand A (unsigned).
REQ-006 SHALL have port b, input, 8, operand B (unsigned).
REQ-007 SHALL have port nib, output, 4, nibble being offered.
REQ-008 SHALL have port slot, output, 2, destination slot: 0=A[3:0], 1=A[7:4], 2=B[3:0], 3=B[7:4].
REQ-009 SHALL have port nib_valid, output, 1, nib/slot valid.
REQ-010 SHALL have port nib_ready, input, 1, receiver accepts nib this cycle.
REQ-011 SHALL have port busy, output, 1, transfer in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the 4th nibble is accepted.

Function
REQ-013 SHALL implement FSM IDLE, SEND, GAP, DONE.
REQ-014 IDLE: start=1 SHALL capture a and b into internal registers, clear the nibble index, and go to SEND; later changes on a/b SHALL NOT affect the transfer.
REQ-015 start SHALL be ignored in SEND, GAP and DONE (no queueing).
REQ-016 SEND: nib_valid=1; nib/slot SHALL stay constant until a cycle with nib_ready=1 (handshake).
REQ-017 On handshake with index<3: index+1; next state GAP if GAP_CYCLES>0, else SEND (next nibble presented the following cycle).
REQ-018 On handshake with index=3: next state DONE.
REQ-019 GAP: nib_valid=0, busy=1; counter runs GAP_CYCLES cycles, then returns to SEND.
REQ-020 DONE: done=1, busy=1, nib_valid=0 for exactly one cycle, then IDLE; start in the DONE cycle SHALL be ignored.
REQ-021 Latency: start sampled at edge N -> nib_valid=1 from edge N+1; with GAP_CYCLES=0 and nib_ready held high, nibbles accepted on cycles N+1..N+4, done on N+5.
REQ-022 nib_ready while nib_valid=0 SHALL have no effect.
REQ-023 busy SHALL be 1 in SEND, GAP and DONE, and 0 in IDLE.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, index=0, gap counter=0, captured operands=0, and nib=0, slot=0, nib_valid=0, busy=0, done=0, including mid-transfer (the partial transfer is abandoned, no done pulse).
REQ-025 start asserted on the first edge after rst_n rises SHALL be honoured.

Configuration
REQ-026 Macro MSN_FIRST_EN defined: slot order 1,0,3,2 (high nibble before low nibble per operand).
REQ-027 Macro MSN_FIRST_EN undefined: slot order 0,1,2,3; nib always equals the operand nibble selected by slot.

Structure
REQ-028 Package operand_nibble_pkg SHALL hold the FSM state typedef and slot constants SLOT_A_LO=0, SLOT_A_HI=1, SLOT_B_LO=2, SLOT_B_HI=3.
REQ-029 The gap counter SHALL be a sub-module gap_counter (load, count-down, expire flag).

Verification
REQ-030 Default order, GAP=0, nib_ready=1, a=8'hA5, b=8'h3C, start one cycle -> (slot,nib) = (0,5),(1,A),(2,C),(3,3) on consecutive cycles; done pulse on the next cycle.
REQ-031 MSN_FIRST_EN, same stimulus -> (1,A),(0,5),(3,3),(2,C).
REQ-032 nib_ready low 3 cycles on the 2nd nibble -> nib/slot held stable; no skipped or duplicated nibble; done delayed by 3 cycles.
REQ-033 GAP_CYCLES=2 -> exactly 2 cycles with nib_valid=0 between transfers; done at cycle N+11.
REQ-034 start re-pulsed mid-transfer with a=8'hFF -> ignored; original nibbles sent; a second start after done sends the new value.
REQ-035 rst_n low during the 3rd nibble -> all outputs 0 on the next edge; no done pulse; a fresh start transmits all 4 nibbles.

Source files
------------

// File: rtl/operand_nibble_pkg.sv
// ============================================================================
// Module : operand_nibble_pkg
// Brief  : Shared types, slot constants and nibble helpers for operand_nibble_tx.
//          Slot order depends on MSN_FIRST_EN (high nibble first when defined).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_nibble_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SLOT_A_LO = 2'd0;
    localparam logic [1:0] SLOT_A_HI = 2'd1;
    localparam logic [1:0] SLOT_B_LO = 2'd2;
    localparam logic [1:0] SLOT_B_HI = 2'd3;

    localparam int unsigned NIBBLES_PER_XFER = 4;

    // Maps the transfer position (0..3) onto the destination slot.
    function automatic logic [1:0] slot_of_index(input logic [1:0] idx);
        logic [1:0] s;
        s = SLOT_A_LO;
`ifdef MSN_FIRST_EN
        case (idx)
            2'd0:    s = SLOT_A_HI;
            2'd1:    s = SLOT_A_LO;
            2'd2:    s = SLOT_B_HI;
            default: s = SLOT_B_LO;
        endcase
`else
        case (idx)
            2'd0:    s = SLOT_A_LO;
            2'd1:    s = SLOT_A_HI;
            2'd2:    s = SLOT_B_LO;
            default: s = SLOT_B_HI;
        endcase
`endif
        return s;
    endfunction

    function automatic logic [3:0] nibble_of(
        input logic [7:0] op_a,
        input logic [7:0] op_b,
        input logic [1:0] s
    );
        logic [3:0] n;
        n = 4'd0;
        case (s)
            SLOT_A_LO: n = op_a[3:0];
            SLOT_A_HI: n = op_a[7:4];
            SLOT_B_LO: n = op_b[3:0];
            default:   n = op_b[7:4];
        endcase
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gap_counter.sv
// ============================================================================
// Module : gap_counter
// Brief  : Loadable down-counter; expired is high on the last counted cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gap_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // A value of 1 (or an unloaded 0) means this is the final idle cycle.
    assign expired = (count[WIDTH-1:1] == '0);

endmodule

`default_nettype wire

// File: rtl/operand_nibble_tx.sv
// ============================================================================
// Module : operand_nibble_tx
// Brief  : Captures an 8-bit a/b operand pair and ships it as four nibbles over
//          a valid/ready link, optionally spaced by GAP_CYCLES idle cycles.
//          Optional macro MSN_FIRST_EN: send high nibble before low nibble.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_nibble_tx
    import operand_nibble_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [3:0] nib,
    output logic [1:0] slot,
    output logic       nib_valid,
    input  logic       nib_ready,
    output logic       busy,
    output logic       done
);

    localparam bit         USE_GAP  = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 15) ? 4'd15 :
                                      (GAP_CYCLES < 0)  ? 4'd0  : 4'(GAP_CYCLES);

    state_t     state;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] idx;
    logic [1:0] idx_next;
    logic       xfer;
    logic       last;
    logic       gap_load;
    logic       gap_dec;
    logic       gap_expired;

    assign idx_next = idx + 2'd1;
    assign xfer     = (state == ST_SEND) && nib_ready;
    assign last     = (idx == 2'(NIBBLES_PER_XFER - 1));
    assign gap_load = USE_GAP && xfer && !last;
    assign gap_dec  = (state == ST_GAP);

    gap_counter #(
        .WIDTH (4)
    ) u_gap_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .expired  (gap_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_a      <= 8'd0;
            op_b      <= 8'd0;
            idx       <= 2'd0;
            nib       <= 4'd0;
            slot      <= 2'd0;
            nib_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // First nibble comes straight from the ports so it is
                        // valid on the cycle right after the capture edge.
                        op_a      <= a;
                        op_b      <= b;
                        idx       <= 2'd0;
                        slot      <= slot_of_index(2'd0);
                        nib       <= nibble_of(a, b, slot_of_index(2'd0));
                        nib_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (nib_ready) begin
                        if (last) begin
                            nib_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            idx <= idx_next;
                            if (USE_GAP) begin
                                nib_valid <= 1'b0;
                                state     <= ST_GAP;
                            end else begin
                                slot <= slot_of_index(idx_next);
                                nib  <= nibble_of(op_a, op_b, slot_of_index(idx_next));
                            end
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_expired) begin
                        slot      <= slot_of_index(idx);
                        nib       <= nibble_of(op_a, op_b, slot_of_index(idx));
                        nib_valid <= 1'b1;
                        state     <= ST_SEND;
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    nib   <= 4'd0;
                    slot  <= 2'd0;
                    idx   <= 2'd0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_operand_nibble_tx.sv
// ============================================================================
// Module : tb_operand_nibble_tx
// Brief  : Drives a GAP_CYCLES=0 and a GAP_CYCLES=2 instance with shared
//          start/a/b/reset and checks both against a transaction-level model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_nibble_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       rdy [2];
    logic [3:0] nib_o [2];
    logic [1:0] slot_o [2];
    logic       nv_o [2];
    logic       busy_o [2];
    logic       done_o [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int gap_of [2] = '{0, 2};
`ifdef MSN_FIRST_EN
    int order_tab [4] = '{1, 0, 3, 2};
    int lit_nib [4]   = '{4'hA, 4'h5, 4'h3, 4'hC};
`else
    int order_tab [4] = '{0, 1, 2, 3};
    int lit_nib [4]   = '{4'h5, 4'hA, 4'hC, 4'h3};
`endif

    // Model: a transfer is "which of the 4 ordered nibbles is next" plus a gap timer.
    bit       m_act [2] = '{0, 0};
    bit       m_vld [2] = '{0, 0};
    bit       m_dn  [2] = '{0, 0};
    int       m_pos [2] = '{0, 0};
    int       m_gap [2] = '{0, 0};
    logic [7:0] m_a [2];
    logic [7:0] m_b [2];
    int       sedge [2] = '{0, 0};
    int       dedge [2] = '{-1, -1};
    int       acc_n [2] = '{0, 0};
    int       acc_s [2][8];
    int       acc_v [2][8];

    always #5 clk = ~clk;

    operand_nibble_tx #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .nib(nib_o[0]), .slot(slot_o[0]), .nib_valid(nv_o[0]),
        .nib_ready(rdy[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    operand_nibble_tx #(.GAP_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .nib(nib_o[1]), .slot(slot_o[1]), .nib_valid(nv_o[1]),
        .nib_ready(rdy[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_nib(input logic [7:0] x, input logic [7:0] y, input int s);
        int v;
        v = (s < 2) ? int'(x) : int'(y);
        return 4'((v >> (4 * (s % 2))) & 15);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n && nv_o[d] && rdy[d] && acc_n[d] < 8) begin
                acc_s[d][acc_n[d]] = int'(slot_o[d]);
                acc_v[d][acc_n[d]] = int'(nib_o[d]);
                acc_n[d]++;
            end
            if (done_o[d]) dedge[d] = cyc;

            if (!rst_n) begin
                m_act[d] = 0; m_vld[d] = 0; m_dn[d] = 0; m_pos[d] = 0; m_gap[d] = 0;
            end else if (m_dn[d]) begin
                m_dn[d] = 0; m_act[d] = 0;
            end else if (!m_act[d]) begin
                if (start) begin
                    m_act[d] = 1; m_vld[d] = 1; m_pos[d] = 0;
                    m_a[d] = a; m_b[d] = b; sedge[d] = cyc;
                end
            end else if (m_vld[d]) begin
                if (rdy[d]) begin
                    m_pos[d]++;
                    if (m_pos[d] == 4) begin
                        m_vld[d] = 0; m_dn[d] = 1;
                    end else if (gap_of[d] > 0) begin
                        m_vld[d] = 0; m_gap[d] = gap_of[d];
                    end
                end
            end else begin
                m_gap[d]--;
                if (m_gap[d] == 0) m_vld[d] = 1;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("nib_valid[%0d]", d), 32'(nv_o[d]), 32'(m_vld[d]));
            check($sformatf("busy[%0d]", d), 32'(busy_o[d]), 32'(m_act[d]));
            check($sformatf("done[%0d]", d), 32'(done_o[d]), 32'(m_dn[d]));
            if (m_vld[d]) begin
                check($sformatf("slot[%0d]", d), 32'(slot_o[d]), 32'(order_tab[m_pos[d]]));
                check($sformatf("nib[%0d]", d), 32'(nib_o[d]),
                      32'(exp_nib(m_a[d], m_b[d], order_tab[m_pos[d]])));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_log();
        for (int d = 0; d < 2; d++) begin
            acc_n[d] = 0;
            dedge[d] = -1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_act[0] || m_act[1]) && n < 300) begin
            step();
            n++;
        end
        if (m_act[0] || m_act[1]) check("idle_timeout", 32'd1, 32'd0);
        step();
    endtask

    task automatic check_log(input int d, input logic [7:0] x, input logic [7:0] y);
        check($sformatf("count[%0d]", d), 32'(acc_n[d]), 32'd4);
        for (int i = 0; i < 4 && i < acc_n[d]; i++) begin
            check($sformatf("log_slot[%0d][%0d]", d, i), 32'(acc_s[d][i]), 32'(order_tab[i]));
            check($sformatf("log_nib[%0d][%0d]", d, i), 32'(acc_v[d][i]),
                  32'(exp_nib(x, y, order_tab[i])));
        end
    endtask

    task automatic pulse_start(input logic [7:0] x, input logic [7:0] y);
        start = 1'b1; a = x; b = y;
        step();
        start = 1'b0;
    endtask

    initial begin
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        step(); step(); step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_nib[%0d]", d), 32'(nib_o[d]), 32'd0);
            check($sformatf("rst_slot[%0d]", d), 32'(slot_o[d]), 32'd0);
        end

        // Basic stream a=A5 b=3C, both ready high.
        rst_n = 1'b1;
        clr_log();
        pulse_start(8'hA5, 8'h3C);
        wait_idle();
        for (int d = 0; d < 2; d++) begin
            check_log(d, 8'hA5, 8'h3C);
            for (int i = 0; i < 4; i++)
                check($sformatf("lit_nib[%0d][%0d]", d, i), 32'(acc_v[d][i]), 32'(lit_nib[i]));
        end
        check("done_lat_gap0", 32'(dedge[0] - sedge[0]), 32'd5);
        check("done_lat_gap2", 32'(dedge[1] - sedge[1]), 32'd11);

        // Stall the 2nd nibble for 3 cycles on the gap-0 instance.
        clr_log();
        start = 1'b1; a = 8'h5E; b = 8'h71;
        step();
        start = 1'b0;
        step();
        rdy[0] = 1'b0;
        step(); step(); step();
        rdy[0] = 1'b1;
        wait_idle();
        check_log(0, 8'h5E, 8'h71);
        check("done_lat_stall", 32'(dedge[0] - sedge[0]), 32'd8);

        // Restart attempt mid-transfer is ignored; later start takes new value.
        clr_log();
        pulse_start(8'h12, 8'h34);
        step();
        pulse_start(8'hFF, 8'h34);
        wait_idle();
        check_log(0, 8'h12, 8'h34);
        check_log(1, 8'h12, 8'h34);
        clr_log();
        pulse_start(8'hFF, 8'h00);
        wait_idle();
        check_log(0, 8'hFF, 8'h00);

        // Reset while the 3rd nibble is on offer.
        clr_log();
        pulse_start(8'hC3, 8'h96);
        for (int n = 0; n < 20 && acc_n[0] < 2; n++) step();
        check("pre_rst_count", 32'(acc_n[0]), 32'd2);
        rst_n = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("mid_rst_nib[%0d]", d), 32'(nib_o[d]), 32'd0);
            check($sformatf("mid_rst_slot[%0d]", d), 32'(slot_o[d]), 32'd0);
            check($sformatf("mid_rst_busy[%0d]", d), 32'(busy_o[d]), 32'd0);
        end
        rst_n = 1'b1;
        clr_log();
        pulse_start(8'h4B, 8'hD2);
        wait_idle();
        check_log(0, 8'h4B, 8'hD2);
        check_log(1, 8'h4B, 8'hD2);

        // Randomized traffic, ready jitter and occasional reset.
        for (int n = 0; n < 2000; n++) begin
            step();
            rst_n  = ($urandom_range(0, 149) != 0);
            start  = ($urandom_range(0, 3) == 0);
            a      = 8'($urandom);
            b      = 8'($urandom);
            rdy[0] = ($urandom_range(0, 9) < 7);
            rdy[1] = ($urandom_range(0, 9) < 7);
        end
        rst_n = 1'b1;
        start = 1'b0;
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
